// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Optional feature macro used by the RTL: DMEM_POSTED_WRITE_EN.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH_DEF   = 1024;
    localparam int unsigned DMEM_LATENCY_DEF = 3;
    localparam int unsigned DMEM_CNT_W       = 4;

    typedef logic [DMEM_CNT_W-1:0] dmem_cnt_t;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    // Counter reload value for an access of the given latency.
    function automatic dmem_cnt_t dmem_lat_load(input int unsigned lat);
        return dmem_cnt_t'(lat - 1);
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Single-entry posted-write buffer for dmem_responder.
// Only instantiated when DMEM_POSTED_WRITE_EN is defined.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int unsigned AW      = 10,
    parameter int unsigned LATENCY = DMEM_LATENCY_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture_i,
    input  logic [AW-1:0] cap_idx_i,
    input  logic [31:0]   cap_data_i,
    input  logic [AW-1:0] lookup_idx_i,
    output logic          full_o,
    output logic          match_o,
    output logic [31:0]   data_o,
    output logic          drain_o,
    output logic [AW-1:0] drain_idx_o
);

    localparam dmem_cnt_t LOAD = dmem_lat_load(LATENCY);

    logic          valid_q, valid_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   data_q, data_d;
    dmem_cnt_t     cnt_q, cnt_d;

    assign full_o      = valid_q;
    assign drain_o     = valid_q && (cnt_q == '0);
    assign match_o     = valid_q && (idx_q == lookup_idx_i);
    assign data_o      = data_q;
    assign drain_idx_o = idx_q;

    // Next-state: a capture wins over a drain in the same cycle, freeing the slot for the new write.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (capture_i) begin
            valid_d = 1'b1;
            idx_d   = cap_idx_i;
            data_d  = cap_data_i;
            cnt_d   = LOAD;
        end else if (drain_o) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            cnt_d = cnt_q - dmem_cnt_t'(1);
        end
    end

    // Buffer registers; reset discards any pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: owns the word array, models a fixed access latency
// and holds the pipeline with dstall until each access completes.
// Optional feature: DMEM_POSTED_WRITE_EN enables a single-entry posted-write buffer.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = DMEM_DEPTH_DEF,
    parameter int unsigned LATENCY = DMEM_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        dstall
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = DMEM_IDLE;
    localparam logic [1:0] BUSY = DMEM_BUSY;
    localparam logic [1:0] DONE = DMEM_DONE;

    localparam dmem_cnt_t LOAD = dmem_lat_load(LATENCY);

    logic [1:0]    state_q, state_d;
    dmem_cnt_t     cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] idx;
    logic          req;
    logic          fsm_start;
    logic          hold_wr;
    logic          complete;
    logic          stall;
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;
    logic [31:0]   rd_word;
    logic          unused_addr;

    assign idx         = ALUOutM[AW+1:2];
    assign unused_addr = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};
    assign req         = MemWriteM | MemtoRegM;

`ifdef DMEM_POSTED_WRITE_EN
    logic          wb_full;
    logic          wb_match;
    logic [31:0]   wb_data;
    logic          wb_drain;
    logic [AW-1:0] wb_drain_idx;
    logic          post_ok;
    logic          wb_capture;

    // The slot is usable when empty or when it drains at this very edge.
    assign post_ok    = ~wb_full | wb_drain;
    assign wb_capture = reset && (state_q == IDLE) && MemWriteM && post_ok;
    assign fsm_start  = MemtoRegM & ~MemWriteM;
    assign hold_wr    = MemWriteM & ~post_ok;
    assign rd_word    = wb_match ? wb_data : mem_q[idx];
    assign mem_we     = wb_drain;
    assign mem_widx   = wb_drain_idx;
    assign mem_wdata  = wb_data;

    dmem_wbuf #(
        .AW      (AW),
        .LATENCY (LATENCY)
    ) u_wbuf (
        .clk          (clk),
        .rst_n        (reset),
        .capture_i    (wb_capture),
        .cap_idx_i    (idx),
        .cap_data_i   (WriteDataM),
        .lookup_idx_i (idx),
        .full_o       (wb_full),
        .match_o      (wb_match),
        .data_o       (wb_data),
        .drain_o      (wb_drain),
        .drain_idx_o  (wb_drain_idx)
    );
`else
    assign fsm_start = req;
    assign hold_wr   = 1'b0;
    assign rd_word   = mem_q[idx];
    assign mem_we    = reset & complete & MemWriteM;
    assign mem_widx  = idx;
    assign mem_wdata = WriteDataM;
`endif

    // FSM next-state, stall and read-data load.
    // The request cycle in IDLE is itself the first stall cycle, so completion
    // happens on the edge where the counter would reach zero (directly from
    // IDLE when LATENCY is 1, else from BUSY with the counter at one); this
    // gives LATENCY stall cycles followed by the single DONE cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        complete = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fsm_start) begin
                    stall = 1'b1;
                    cnt_d = LOAD;
                    if (LOAD == '0) begin
                        complete = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end else if (hold_wr) begin
                    stall = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - dmem_cnt_t'(1);
                if (cnt_q == dmem_cnt_t'(1)) begin
                    complete = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (complete && !MemWriteM) begin
            rdata_d = rd_word;
        end
    end

    assign dstall    = reset & stall;
    assign ReadDataM = rdata_q;

    // Control and read-data registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Word array write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=3/DEPTH=1024 instance driven from
// a vector table plus hand sequences, and a LATENCY=1/DEPTH=16 instance.
module tb_dmem_responder;

`ifdef DMEM_POSTED_WRITE_EN
    localparam int WSTALL0 = 0;
    localparam int WSTALL1 = 0;
`else
    localparam int WSTALL0 = 3;
    localparam int WSTALL1 = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, re0, ds0;
    logic [31:0] addr0, wd0, rd0;
    logic        we1, re1, ds1;
    logic [31:0] addr1, wd1, rd1;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH(1024), .LATENCY(3)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (we0),
        .MemtoRegM  (re0),
        .ALUOutM    (addr0),
        .WriteDataM (wd0),
        .ReadDataM  (rd0),
        .dstall     (ds0)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (we1),
        .MemtoRegM  (re1),
        .ALUOutM    (addr1),
        .WriteDataM (wd1),
        .ReadDataM  (rd1),
        .dstall     (ds1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_stall;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            we0 = we; re0 = re; addr0 = a; wd0 = wd;
        end else begin
            we1 = we; re1 = re; addr1 = a; wd1 = wd;
        end
    endtask

    // One access starting on the next cycle; counts stall cycles and returns
    // ReadDataM from the first non-stalled cycle. Bounded at 40 cycles.
    task automatic do_access(input int sel, input logic we, input logic re,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int stalls, output logic [31:0] rd);
        logic d;
        stalls = 0;
        rd     = 32'hxxxx_xxxx;
        @(posedge clk); #1;
        drive(sel, we, re, a, wd);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            d = (sel == 0) ? ds0 : ds1;
            if (d) begin
                stalls++;
            end else begin
                rd = (sel == 0) ? rd0 : rd1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int          st;
        logic [31:0] rd;
        logic [7:0]  pat;

        tbl[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, WSTALL0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         3,       32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 1'b0, 32'h0000_1004, 32'h5A5A_5A5A, WSTALL0, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,         3,       32'h5A5A_5A5A};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h0,         3,       32'h5A5A_5A5A};
        tbl[5]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0001, WSTALL0, 32'h5A5A_5A5A};
        tbl[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         3,       32'h0000_0001};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_1004, 32'h0,         3,       32'h5A5A_5A5A};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h1357_9BDF, WSTALL0, 32'h5A5A_5A5A};
        tbl[9]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0,         3,       32'h1357_9BDF};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         3,       32'hDEAD_BEEF};

        // Reset with a request held: no stall, read data cleared.
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_dstall0", {31'd0, ds0}, 32'd0);
        check("rst_rdata0", rd0, 32'd0);
        check("rst_dstall1", {31'd0, ds1}, 32'd0);
        check("rst_rdata1", rd1, 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven accesses on the LATENCY=3 instance.
        for (int i = 0; i < 11; i++) begin
            do_access(0, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, st, rd);
            check($sformatf("vec%0d_stall", i), st, tbl[i].exp_stall);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end

        // ReadDataM holds with no request.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rdata_hold", rd0, 32'hDEAD_BEEF);
        check("idle_dstall", {31'd0, ds0}, 32'd0);

        // Back-to-back reads of 0x0 then 0x4: dstall 1110_1110.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'h0, 32'h0);
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) addr0 = 32'h4;
            @(negedge clk);
            pat = {pat[6:0], ds0};
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b_pattern", {24'd0, pat}, {24'd0, 8'b1110_1110});
        check("b2b_rdata", rd0, 32'h5A5A_5A5A);

        // Reset in the middle of a write to 0x40 aborts it.
        do_access(0, 1'b1, 1'b0, 32'h40, 32'hCAFE_0001, st, rd);
        check("pre40_stall", st, WSTALL0);
        do_access(0, 1'b0, 1'b1, 32'h40, 32'h0, st, rd);
        check("pre40_rdata", rd, 32'hCAFE_0001);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h40, 32'hBADB_AD00);
        @(negedge clk);
        check("abort_first_dstall", {31'd0, ds0}, {31'd0, (WSTALL0 != 0)});
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_dstall", {31'd0, ds0}, 32'd0);
        check("abort_rdata_clr", rd0, 32'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        do_access(0, 1'b0, 1'b1, 32'h40, 32'h0, st, rd);
        check("abort_read_stall", st, 3);
        check("abort_read40", rd, 32'hCAFE_0001);

`ifdef DMEM_POSTED_WRITE_EN
        // Posted write followed by an immediate read; then a write into a full buffer.
        do_access(0, 1'b1, 1'b0, 32'h8, 32'h11, st, rd);
        check("pw_write_stall", st, 0);
        do_access(0, 1'b0, 1'b1, 32'h8, 32'h0, st, rd);
        check("pw_read_stall", st, 3);
        check("pw_read_data", rd, 32'h11);
        do_access(0, 1'b1, 1'b0, 32'h8, 32'h22, st, rd);
        check("pw_w1_stall", st, 0);
        do_access(0, 1'b1, 1'b0, 32'hC, 32'h33, st, rd);
        check("pw_w2_stall", st, 2);
        do_access(0, 1'b0, 1'b1, 32'hC, 32'h0, st, rd);
        check("pw_readC", rd, 32'h33);
        do_access(0, 1'b0, 1'b1, 32'h8, 32'h0, st, rd);
        check("pw_read8", rd, 32'h22);
`endif
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // LATENCY=1 instance: one stall cycle, DONE on the second; DEPTH=16 wrap.
        do_access(1, 1'b1, 1'b0, 32'h8, 32'hA5A5_A5A5, st, rd);
        check("l1_write_stall", st, WSTALL1);
        check("l1_write_rdata", rd, 32'h0);
        do_access(1, 1'b0, 1'b1, 32'h8, 32'h0, st, rd);
        check("l1_read_stall", st, 1);
        check("l1_read_data", rd, 32'hA5A5_A5A5);
        do_access(1, 1'b0, 1'b1, 32'h48, 32'h0, st, rd);
        check("l1_wrap_data", rd, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
